// File: rtl/serial_2sc_ctrl.sv
// rtl/serial_2sc_ctrl.sv - word-level controller for an external bit-serial two's-complement unit
// Feeds the operand LSB first and assembles the Mealy serial result back into a parallel word.
module serial_2sc_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req,
   input  logic [WIDTH-1:0] din,
   input  logic             abort,
   output logic             ready,
   output logic             ser_start,
   output logic             ser_data,
   input  logic             ser_pout,
   output logic [WIDTH-1:0] dout,
   output logic             done,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] op_q, op_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             neg_q, neg_d;
   logic             ovf_q, ovf_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= '0;
         res_q   <= '0;
         dout_q  <= '0;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         res_q   <= res_d;
         dout_q  <= dout_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      res_d   = res_q;
      dout_d  = dout_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            // req beats a simultaneous abort; abort means nothing here
            if (req) begin
               op_d    = din;
               neg_d   = (din == MIN_NEG);
               res_d   = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               op_d  = op_q >> 1;
               res_d = {ser_pout, res_q[WIDTH-1:1]};
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  dout_d  = {ser_pout, res_q[WIDTH-1:1]};
                  ovf_d   = neg_q;
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign ready     = (state_q == IDLE);
   assign ser_start = (state_q == SHIFT);
   assign ser_data  = (state_q == SHIFT) & op_q[0];
   assign done      = (state_q == DONE);
   assign dout      = dout_q;
   assign ovf       = ovf_q;

endmodule

// File: doc/serial_2sc_ctrl.md
SERIAL_2SC_CTRL -- requirements
Module: serial_2sc_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, word length in bits; legal range 2..32.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  1  request to negate din; sampled only when ready=1.
REQ-005 Port: din  input  WIDTH  parallel operand, captured with an accepted req.
REQ-006 Port: abort  input  1  synchronous cancel of the word in progress.
REQ-007 Port: ready  output  1  controller idle and able to accept req.
REQ-008 Port: ser_start  output  1  enable to the serial two's-complement unit; low clears that unit's seen-one state.
REQ-009 Port: ser_data  output  1  serial operand bit to the unit, LSB first.
REQ-010 Port: ser_pout  input  1  serial result bit from the unit, valid in the same cycle as ser_data (Mealy).
REQ-011 Port: dout  output  WIDTH  parallel two's-complement result.
REQ-012 Port: done  output  1  one-cycle pulse; dout and ovf are valid.
REQ-013 Port: ovf  output  1  operand was the most-negative value (only MSB set), so the result equals the operand.

Function
REQ-014 FSM states: IDLE, SHIFT and DONE; the state is encoded in registers updated on the rising edge of clk.
REQ-015 IDLE: ready=1, ser_start=0, ser_data=0; req=1 at an edge loads din into the shift register, clears the bit counter, and moves to SHIFT.
REQ-016 SHIFT: ready=0, ser_start=1, ser_data=shift register bit 0; this state lasts exactly WIDTH cycles.
REQ-017 SHIFT edge action: shift the operand register right by 1; shift ser_pout into the MSB of the result register (right shift); increment the counter.
REQ-018 SHIFT edge with counter = WIDTH-1: load dout with {ser_pout, result[WIDTH-1:1]}; register ovf; move to DONE.
REQ-019 DONE: done=1 for exactly 1 cycle, ser_start=0, ready=0, then unconditionally move to IDLE.
REQ-020 Latency: req accepted at edge N gives done=1 during the cycle after edge N+WIDTH; throughput is one word per WIDTH+2 cycles.
REQ-021 ser_start is low for at least 2 cycles between consecutive words (DONE plus IDLE), guaranteeing the unit is cleared.
REQ-022 req while ready=0 is ignored and is not queued; din is not sampled.
REQ-023 abort=1 in SHIFT: return to IDLE at the next edge; no done; dout and ovf hold their previous values.
REQ-024 abort in IDLE or DONE has no effect.
REQ-025 abort and req together in IDLE: req wins.
REQ-026 dout and ovf hold their values until the next done; they do not change during SHIFT.
REQ-027 ovf=1 iff the captured operand equals 1 followed by WIDTH-1 zeros; it is computed from the captured operand, not from ser_pout.
REQ-028 An operand of zero gives dout=0 and ovf=0.

Reset
REQ-029 On reset assertion, the controller immediately enters IDLE, including from mid-SHIFT, and the word in progress is discarded with no done.
REQ-030 Reset values: ready=1, ser_start=0, ser_data=0, dout=0, done=0, ovf=0, counter=0, and the shift and result registers are 0.
REQ-031 Deassertion: the first req is accepted at the first rising edge after reset falls.

Verification (WIDTH=8, with the serial two's-complement unit attached)
REQ-032 din=0x05, 1-cycle req -> done pulse 9 cycles later; dout=0xFB, ovf=0; ser_data sequence 1,0,1,0,0,0,0,0.
REQ-033 din=0x80 -> dout=0x80, ovf=1.
REQ-034 din=0x00 -> dout=0x00, ovf=0; din=0x01 -> dout=0xFF.
REQ-035 req held high continuously with din=0x05 then 0x7F -> done at 10-cycle spacing; dout=0xFB then 0x81; ser_start low 2 cycles between words; no req is dropped while ready=1.
REQ-036 abort after 3 SHIFT cycles of din=0x3C -> IDLE next cycle, no done, dout unchanged; the next word 0x02 gives dout=0xFE, proving the unit was cleared.
REQ-037 Reset asserted in SHIFT cycle 5 -> all outputs at reset values asynchronously; no done; the post-reset word 0x10 gives dout=0xF0.
